// File: rtl/module_divider_if.sv
// Operand/result handshake bundle for module_divider.
//   start        : request a division (sampled on the rising clock edge)
//   dividend1    : dividend, captured only on an accepted start
//   divisor1     : divisor, captured only on an accepted start
//   quotient     : registered quotient of the last completed operation
//   remainder    : registered remainder of the last completed operation
//   busy         : high while an operation is in progress
//   done         : one-cycle pulse when quotient/remainder update
//   div_by_zero  : set when the last completed operation had a zero divisor
interface module_divider_if #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
);
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend1;
  logic [DIVISOR_W-1:0]  divisor1;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  busy;
  logic                  done;
  logic                  div_by_zero;

  modport master (
    output start, dividend1, divisor1,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend1, divisor1,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/module_divider.sv
// Sequential restoring shift-subtract divider, one quotient bit per clock.
// Companion of the shift-add multiplier; shares its start/busy handshake.
// Ports:
//   clock : system clock, all state updates on the rising edge
//   reset : synchronous, active-high reset
//   bus   : module_divider_if.slave (operands in, registered results out)
//
// state | meaning
// IDLE  | waiting for start; results held; done may be pulsing
// RUN   | one restoring iteration per cycle, counter DIVIDEND_W-1 down to 0
// ZERO  | divisor was zero; publish saturated quotient next edge
module module_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input logic             clock,
  input logic             reset,
  module_divider_if.slave bus
);
  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, ZERO} state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVIDEND_W-1:0] quo_sh_q;
  logic [DIVISOR_W-1:0]  dsr_q;
  logic [DIVISOR_W:0]    prem_q;
  logic [DIVIDEND_W-1:0] quotient_q;
  logic [DIVISOR_W-1:0]  remainder_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  dbz_q;

  logic [DIVISOR_W:0]    shifted;
  logic                  qbit_d;
  logic [DIVISOR_W:0]    prem_d;
  logic [DIVIDEND_W-1:0] quo_sh_d;

  // The partial remainder is always below the divisor, so after shifting in
  // the next dividend bit it fits in DIVISOR_W+1 bits and the trial subtract
  // reduces to an unsigned compare.
  always_comb begin
    shifted  = (prem_q << 1) | {{DIVISOR_W{1'b0}}, dvd_q[DIVIDEND_W-1]};
    qbit_d   = (shifted >= {1'b0, dsr_q});
    prem_d   = qbit_d ? (shifted - {1'b0, dsr_q}) : shifted;
    quo_sh_d = (quo_sh_q << 1) | {{(DIVIDEND_W-1){1'b0}}, qbit_d};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      quo_sh_q    <= '0;
      dsr_q       <= '0;
      prem_q      <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            dvd_q    <= bus.dividend1;
            dsr_q    <= bus.divisor1;
            prem_q   <= '0;
            quo_sh_q <= '0;
            cnt_q    <= CNT_W'(DIVIDEND_W - 1);
            busy_q   <= 1'b1;
            state_q  <= (bus.divisor1 == '0) ? ZERO : RUN;
          end
        end
        RUN: begin
          dvd_q    <= dvd_q << 1;
          prem_q   <= prem_d;
          quo_sh_q <= quo_sh_d;
          if (cnt_q == '0) begin
            quotient_q  <= quo_sh_d;
            remainder_q <= prem_d[DIVISOR_W-1:0];
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ZERO: begin
          quotient_q  <= '1;
          remainder_q <= '0;
          dbz_q       <= 1'b1;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_module_divider.sv
module tb_module_divider;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  module_divider_if bus ();

  module_divider dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Accepts an operation at the next edge; afterwards operands are scrambled
  // to show the result does not depend on them past the accepting edge.
  task automatic start_op(input logic [7:0] a, input logic [3:0] b);
    bus.start     = 1'b1;
    bus.dividend1 = a;
    bus.divisor1  = b;
    tick();
    bus.start     = 1'b0;
    bus.dividend1 = 8'hA5;
    bus.divisor1  = 4'hC;
  endtask

  // Counts busy cycles from the current cycle until busy falls; done must be
  // low while busy.
  task automatic wait_done(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 30) begin
      check("done_low_while_busy", 32'(bus.done), 0);
      n++;
      tick();
    end
  endtask

  task automatic finish_op(input string tag, input int pre, input int exp_busy,
                           input logic [7:0] q, input logic [3:0] r, input logic dbz);
    int n;
    wait_done(n);
    check({tag, "_busy_cycles"}, 32'(pre + n), 32'(exp_busy));
    check({tag, "_done"}, 32'(bus.done), 1);
    check({tag, "_quotient"}, 32'(bus.quotient), 32'(q));
    check({tag, "_remainder"}, 32'(bus.remainder), 32'(r));
    check({tag, "_div_by_zero"}, 32'(bus.div_by_zero), 32'(dbz));
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.dividend1 = '0;
    bus.divisor1  = '0;

    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("reset_idle_outputs",
            {11'b0, bus.busy, bus.done, bus.div_by_zero, bus.remainder, bus.quotient}, 0);
      tick();
    end

    // 15/5, then a new start in the done cycle
    start_op(8'd15, 4'd5);
    finish_op("d15_5", 0, 8, 8'd3, 4'd0, 1'b0);
    start_op(8'd100, 4'd7);
    check("start_in_done_done_falls", 32'(bus.done), 0);
    check("start_in_done_busy_rises", 32'(bus.busy), 1);
    finish_op("d100_7", 0, 8, 8'd14, 4'd2, 1'b0);
    tick();
    check("done_one_cycle", 32'(bus.done), 0);
    check("result_held", 32'(bus.quotient), 14);

    start_op(8'd255, 4'd1);
    finish_op("d255_1", 0, 8, 8'd255, 4'd0, 1'b0);
    tick();
    start_op(8'd7, 4'd9);
    finish_op("d7_9", 0, 8, 8'd0, 4'd7, 1'b0);
    tick();
    start_op(8'd255, 4'd15);
    finish_op("d255_15", 0, 8, 8'd17, 4'd0, 1'b0);
    tick();

    start_op(8'd42, 4'd0);
    finish_op("d42_0", 0, 1, 8'hFF, 4'd0, 1'b1);
    tick();
    check("dbz_done_one_cycle", 32'(bus.done), 0);
    start_op(8'd9, 4'd3);
    finish_op("d9_3", 0, 8, 8'd3, 4'd0, 1'b0);
    tick();

    // start during busy is ignored
    start_op(8'd200, 4'd9);
    tick();
    tick();
    tick();
    check("busy_cycle4", 32'(bus.busy), 1);
    check("outputs_stable_in_run", 32'(bus.quotient), 3);
    bus.start     = 1'b1;
    bus.dividend1 = 8'd10;
    bus.divisor1  = 4'd2;
    tick();
    bus.start     = 1'b0;
    finish_op("d200_9_restart_ignored", 4, 8, 8'd22, 4'd2, 1'b0);
    tick();

    // reset mid-operation
    start_op(8'd200, 4'd9);
    tick();
    tick();
    tick();
    tick();
    check("busy_cycle5_before_reset", 32'(bus.busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midop_reset_outputs",
          {11'b0, bus.busy, bus.done, bus.div_by_zero, bus.remainder, bus.quotient}, 0);
    for (int i = 0; i < 10; i++) begin
      check("no_done_after_reset", {30'b0, bus.busy, bus.done}, 0);
      tick();
    end
    start_op(8'd50, 4'd6);
    finish_op("d50_6", 0, 8, 8'd8, 4'd2, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
